conv_result_writer: RTL and testbench

CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

---
 rtl/conv_result_writer_pkg.sv | 19 +
 rtl/conv_result_writer_if.sv | 27 ++
 rtl/conv_sat_relu.sv | 30 +++
 rtl/conv_result_writer.sv | 127 ++++++++++++
 tb/tb_conv_result_writer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_result_writer_pkg.sv
// Shared types and saturation helpers for the conv result writer.
package conv_result_writer_pkg;

  typedef enum logic [1:0] {StIdle, StWrite, StFinish} wr_state_e;

  localparam int unsigned DefDataWidth = 16;

  function automatic longint sat_max(int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  localparam longint DefSatMax = sat_max(DefDataWidth);
  localparam longint DefSatMin = sat_min(DefDataWidth);

endpackage

// File: rtl/conv_result_writer_if.sv
// Accumulator-in / BRAM-write-out bundle of the conv result writer.
interface conv_result_writer_if #(
  parameter int unsigned ACC_WIDTH          = 32,
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned ADDRESS_LENGTH_OUT = 12
);
  logic                          start;
  logic                          in_valid;
  logic [ACC_WIDTH-1:0]          in_data;
  logic                          in_ready;
  logic                          ena_out;
  logic                          wea_out;
  logic [ADDRESS_LENGTH_OUT-1:0] addra_out;
  logic [DATA_WIDTH-1:0]         dina_out;
  logic                          busy;
  logic                          done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, ena_out, wea_out, addra_out, dina_out, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, ena_out, wea_out, addra_out, dina_out, busy, done
  );
endinterface

// File: rtl/conv_sat_relu.sv
// Combinational fixed-point rescale: arithmetic shift, saturate, optional ReLU.
module conv_sat_relu
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  output logic signed [DATA_WIDTH-1:0] o_data
);
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ACC_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic signed [DATA_WIDTH-1:0] w_sat;

  always_comb begin
    w_shifted = i_acc >>> FRAC_SHIFT;
    if (w_shifted > SatMax) begin
      w_sat = SatMax[DATA_WIDTH-1:0];
    end else if (w_shifted < SatMin) begin
      w_sat = SatMin[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shifted[DATA_WIDTH-1:0];
    end
    o_data = (RELU_EN && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
  end
endmodule

// File: rtl/conv_result_writer.sv
// Streams accumulator results into a channel-major output BRAM, one word per accepted transfer.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned OUT_CHANNEL        = 6,
  parameter int unsigned OUT_WIDTH          = 24,
  parameter int unsigned OUT_HEIGHT         = 24,
  parameter int unsigned ACC_WIDTH          = 32,
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned FRAC_SHIFT         = 8,
  parameter bit          RELU_EN            = 1'b1,
  parameter int unsigned ADDRESS_LENGTH_OUT = 12
) (
  input logic                 clk,
  input logic                 rstn,
  conv_result_writer_if.slave bus
);
  localparam int unsigned ColW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int unsigned RowW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int unsigned ChW  = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1;

  wr_state_e                     r_state;
  logic [ColW-1:0]               r_col;
  logic [RowW-1:0]               r_row;
  logic [ChW-1:0]                r_ch;
  logic [ADDRESS_LENGTH_OUT-1:0] r_addr;
  logic                          r_in_ready;
  logic                          r_ena;
  logic                          r_busy;
  logic                          r_done;
  logic [ADDRESS_LENGTH_OUT-1:0] r_addra;
  logic [DATA_WIDTH-1:0]         r_dina;

  logic signed [DATA_WIDTH-1:0] w_result;
  logic                         w_fire;
  logic                         w_last_col;
  logic                         w_last_row;
  logic                         w_last_ch;

  conv_sat_relu #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_sat_relu (
    .i_acc  ($signed(bus.in_data)),
    .o_data (w_result)
  );

  assign w_fire     = bus.in_valid && r_in_ready;
  assign w_last_col = (r_col == ColW'(OUT_WIDTH - 1));
  assign w_last_row = (r_row == RowW'(OUT_HEIGHT - 1));
  assign w_last_ch  = (r_ch == ChW'(OUT_CHANNEL - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_col      <= '0;
      r_row      <= '0;
      r_ch       <= '0;
      r_addr     <= '0;
      r_in_ready <= 1'b0;
      r_ena      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addra    <= '0;
      r_dina     <= '0;
    end else begin
      r_ena  <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state    <= StWrite;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_col      <= '0;
            r_row      <= '0;
            r_ch       <= '0;
            r_addr     <= '0;
          end
        end
        StWrite: begin
          if (w_fire) begin
            r_ena   <= 1'b1;
            r_addra <= r_addr;
            r_dina  <= w_result;
            r_addr  <= r_addr + 1'b1;
            // Counter order matches channel-major addressing, so the address just increments.
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_row <= '0;
                if (w_last_ch) begin
                  r_ch       <= '0;
                  r_state    <= StFinish;
                  r_in_ready <= 1'b0;
                end else begin
                  r_ch <= r_ch + 1'b1;
                end
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        StFinish: begin
          // Outputs are registered, so done/busy land one cycle after the final write.
          r_state <= StIdle;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.ena_out   = r_ena;
  assign bus.wea_out   = r_ena;
  assign bus.addra_out = r_addra;
  assign bus.dina_out  = r_dina;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: saturation table plus multi-cycle frame sequences.
module tb_conv_result_writer;
  localparam int unsigned Total = 3456;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_result_writer_if #(.ACC_WIDTH(32), .DATA_WIDTH(16), .ADDRESS_LENGTH_OUT(12)) bus_a ();
  conv_result_writer_if #(.ACC_WIDTH(32), .DATA_WIDTH(16), .ADDRESS_LENGTH_OUT(12)) bus_b ();

  conv_result_writer dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  conv_result_writer #(
    .OUT_CHANNEL (1),
    .OUT_WIDTH   (3),
    .OUT_HEIGHT  (3),
    .RELU_EN     (1'b0)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  typedef struct {
    logic [31:0] din;
    logic [15:0] exp_relu;
    logic [15:0] exp_raw;
  } vec_t;

  vec_t tbl [9];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa_addr[$];
  int wa_data[$];
  int wb_addr[$];
  int wb_data[$];
  int last_wr_cyc_a, done_a_cnt, done_a_cyc, busy_done_err, hold_err, wea_err, done_b_cnt;
  logic [11:0] last_addr;
  logic [15:0] last_data;

  always @(negedge clk) begin
    if (!rstn) begin
      last_addr = '0;
      last_data = '0;
    end
    if (bus_a.ena_out) begin
      wa_addr.push_back(int'(bus_a.addra_out));
      wa_data.push_back(int'(bus_a.dina_out));
      last_wr_cyc_a = cyc;
      last_addr = bus_a.addra_out;
      last_data = bus_a.dina_out;
    end else if (bus_a.addra_out !== last_addr || bus_a.dina_out !== last_data) begin
      hold_err++;
    end
    if (bus_a.wea_out !== bus_a.ena_out) wea_err++;
    if (bus_a.done) begin
      done_a_cnt++;
      done_a_cyc = cyc;
      if (bus_a.busy) busy_done_err++;
    end
    if (bus_b.ena_out) begin
      wb_addr.push_back(int'(bus_b.addra_out));
      wb_data.push_back(int'(bus_b.dina_out));
    end
    if (bus_b.done) done_b_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_addr.delete();
    wa_data.delete();
    wb_addr.delete();
    wb_data.delete();
    last_wr_cyc_a = -100;
    done_a_cnt    = 0;
    done_a_cyc    = -1;
    busy_done_err = 0;
    hold_err      = 0;
    wea_err       = 0;
    done_b_cnt    = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Drives one frame on dut_a; stops early after abort_at transfers, pulses start at start_mid_at.
  task automatic run_frame(input bit gaps, input int abort_at, input int start_mid_at,
                           output int accepted);
    int  k = 0;
    int  budget = 0;
    bit  v;
    bit  acc;
    bit  mid_sent = 1'b0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    while (k < int'(Total) && k != abort_at && budget < 20000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_a.in_valid = v;
      bus_a.in_data  = 32'(k) << 8;
      bus_a.start    = 1'b0;
      if (k == start_mid_at && !mid_sent) begin
        bus_a.start = 1'b1;
        mid_sent    = 1'b1;
      end
      acc = v && bus_a.in_ready;
      tick();
      budget++;
      if (acc) k++;
    end
    bus_a.start = 1'b0;
    accepted = k;
  endtask

  task automatic check_frame(input string tag, input int n);
    int bad = 0;
    chk({tag, "_count"}, 64'(wa_addr.size()), 64'(n));
    for (int i = 0; i < wa_addr.size(); i++) begin
      if (wa_addr[i] != i || wa_data[i] != i) bad++;
    end
    chk({tag, "_seq_bad"}, 64'(bad), 64'd0);
    chk({tag, "_hold"}, 64'(hold_err), 64'd0);
    chk({tag, "_wea"}, 64'(wea_err), 64'd0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done_cnt"}, 64'(done_a_cnt), 64'd1);
    chk({tag, "_done_lat"}, 64'(done_a_cyc - last_wr_cyc_a), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy_done_err), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus_a.busy), 64'd0);
    chk({tag, "_ready_after"}, 64'(bus_a.in_ready), 64'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF};
    tbl[1] = '{32'hFFFF_FB00, 16'h0000, 16'hFFFB};
    tbl[2] = '{32'h8000_0000, 16'h0000, 16'h8000};
    tbl[3] = '{32'h0000_1234, 16'h0012, 16'h0012};
    tbl[4] = '{32'h007F_FF00, 16'h7FFF, 16'h7FFF};
    tbl[5] = '{32'h0080_0000, 16'h7FFF, 16'h7FFF};
    tbl[6] = '{32'hFF80_0000, 16'h0000, 16'h8000};
    tbl[7] = '{32'h0000_00FF, 16'h0000, 16'h0000};
    tbl[8] = '{32'hFFFF_FFFF, 16'h0000, 16'hFFFF};

    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    clear_mon();
    tick();
    tick();
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("rst_ena", 64'(bus_a.ena_out), 64'd0);
    chk("rst_wea", 64'(bus_a.wea_out), 64'd0);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_done", 64'(bus_a.done), 64'd0);
    chk("rst_addra", 64'(bus_a.addra_out), 64'd0);
    chk("rst_dina", 64'(bus_a.dina_out), 64'd0);
    rstn = 1'b1;
    tick();

    // Write latency and hold behaviour around a gap.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("lat_busy", 64'(bus_a.busy), 64'd1);
    chk("lat_ready", 64'(bus_a.in_ready), 64'd1);
    chk("lat_idle_ena", 64'(bus_a.ena_out), 64'd0);
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'h0000_0A00;
    tick();
    chk("lat_ena", 64'(bus_a.ena_out), 64'd1);
    chk("lat_wea", 64'(bus_a.wea_out), 64'd1);
    chk("lat_addr0", 64'(bus_a.addra_out), 64'd0);
    chk("lat_data0", 64'(bus_a.dina_out), 64'h0A);
    bus_a.in_valid = 1'b0;
    tick();
    chk("gap_ena", 64'(bus_a.ena_out), 64'd0);
    chk("gap_hold_addr", 64'(bus_a.addra_out), 64'd0);
    chk("gap_hold_data", 64'(bus_a.dina_out), 64'h0A);
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'h0000_0B00;
    tick();
    bus_a.in_valid = 1'b0;
    chk("lat_addr1", 64'(bus_a.addra_out), 64'd1);
    chk("lat_data1", 64'(bus_a.dina_out), 64'h0B);
    do_reset();

    // Saturation / ReLU table on both ReLU settings.
    clear_mon();
    bus_a.start = 1'b1; bus_b.start = 1'b1;
    tick();
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = tbl[i].din;
      bus_b.in_valid = 1'b1; bus_b.in_data = tbl[i].din;
      tick();
    end
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("tbl_a_count", 64'(wa_addr.size()), 64'd9);
    chk("tbl_b_count", 64'(wb_addr.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < wa_addr.size()) begin
        chk($sformatf("tbl_relu_addr%0d", i), 64'(wa_addr[i]), 64'(i));
        chk($sformatf("tbl_relu_data%0d", i), 64'(wa_data[i]), 64'(tbl[i].exp_relu));
      end
      if (i < wb_addr.size()) begin
        chk($sformatf("tbl_raw_addr%0d", i), 64'(wb_addr[i]), 64'(i));
        chk($sformatf("tbl_raw_data%0d", i), 64'(wb_data[i]), 64'(tbl[i].exp_raw));
      end
    end
    chk("tbl_b_done", 64'(done_b_cnt), 64'd1);
    do_reset();

    // in_valid while idle, then a full frame with in_valid stuck high.
    clear_mon();
    bus_a.in_valid = 1'b1; bus_a.in_data = 32'h0000_7700;
    tick(); tick(); tick();
    bus_a.in_valid = 1'b0;
    chk("idle_valid_writes", 64'(wa_addr.size()), 64'd0);
    run_frame(1'b0, -1, -1, n);
    bus_a.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("full_accepted", 64'(n), 64'(Total));
    check_frame("full", int'(Total));
    chk("ch_boundary_575", 64'((wa_addr.size() > 576) ? wa_addr[575] : -1), 64'd575);
    chk("ch_boundary_576", 64'((wa_addr.size() > 576) ? wa_addr[576] : -1), 64'd576);
    check_done("full");

    // Random gaps with a stray start pulse mid-frame.
    clear_mon();
    run_frame(1'b1, -1, 100, n);
    bus_a.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("gaps_accepted", 64'(n), 64'(Total));
    check_frame("gaps", int'(Total));
    check_done("gaps");

    // Reset mid-frame, then a clean restart.
    clear_mon();
    run_frame(1'b0, 1000, -1, n);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    tick(); tick(); tick();
    chk("abort_ena", 64'(bus_a.ena_out), 64'd0);
    chk("abort_busy", 64'(bus_a.busy), 64'd0);
    chk("abort_addra", 64'(bus_a.addra_out), 64'd0);
    chk("abort_dina", 64'(bus_a.dina_out), 64'd0);
    rstn = 1'b1;
    tick(); tick(); tick();
    bus_a.in_valid = 1'b0;
    check_frame("abort", 1000);
    chk("abort_done", 64'(done_a_cnt), 64'd0);
    clear_mon();
    run_frame(1'b0, -1, -1, n);
    bus_a.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("restart_first_addr", 64'((wa_addr.size() > 0) ? wa_addr[0] : -1), 64'd0);
    check_frame("restart", int'(Total));
    check_done("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
